// File: rtl/seq_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : seq_bit_serializer
//  Description : Parallel-to-serial feed stage for the 1011 sequence
//                detector. Words arrive over a valid/ready handshake and
//                leave as a continuous one-bit-per-clock stream. A one-entry
//                holding register lets consecutive words stream back-to-back
//                so patterns spanning word boundaries stay intact.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_bit_serializer #(
  parameter int WIDTH     = 8,    // word width in bits, must be >= 2
  parameter bit MSB_FIRST = 1'b1  // 1: bit WIDTH-1 leaves first, 0: bit 0 first
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_bit,
  output logic             bit_valid,
  output logic             word_last,
  output logic             busy
);

  localparam int              c_CW       = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_st;
  logic [WIDTH-1:0] r_sh;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;

  logic             w_ready;
  logic             w_accept;
  logic             w_shifting;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_sh_adv;
  logic             w_out_bit;

  // Ready depends only on the holding flag, never on data_valid, so the
  // source can decide to present a word without a combinational loop.
  assign w_ready    = !r_hold_full;
  assign w_accept   = data_valid && w_ready;
  assign w_shifting = (r_st == ST_SHIFT);
  assign w_last_bit = w_shifting && (r_cnt == c_CNT_LAST);

  // The output position and shift direction follow the bit order: the
  // output bit sits at the end that leaves first, the rest move toward it.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sh_adv  = {r_sh[WIDTH-2:0], 1'b0};
      assign w_out_bit = r_sh[WIDTH-1];
    end else begin : g_lsb_first
      assign w_sh_adv  = {1'b0, r_sh[WIDTH-1:1]};
      assign w_out_bit = r_sh[0];
    end
  endgenerate

  // Control FSM, shifter, bit counter and holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st        <= ST_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          // Idle accept goes straight into the shifter; hold stays empty.
          if (w_accept) begin
            r_sh  <= data_in;
            r_cnt <= '0;
            r_st  <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (r_cnt != c_CNT_LAST) begin
            r_sh  <= w_sh_adv;
            r_cnt <= r_cnt + c_CNT_ONE;
            // A word arriving mid-word is parked until the shifter drains.
            if (w_accept) begin
              r_hold      <= data_in;
              r_hold_full <= 1'b1;
            end
          end else if (r_hold_full) begin
            // Parked word wins over new input; ready is low this cycle.
            r_sh        <= r_hold;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
          end else if (w_accept) begin
            // Word offered on the final bit bypasses the holding register.
            r_sh  <= data_in;
            r_cnt <= '0;
          end else begin
            r_st <= ST_IDLE;
          end
        end

        default: begin
          r_st <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from state only; idle gaps read as '0' bits.
  assign data_ready = w_ready;
  assign ser_bit    = w_shifting ? w_out_bit : 1'b0;
  assign bit_valid  = w_shifting;
  assign word_last  = w_last_bit;
  assign busy       = w_shifting || r_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_bit_serializer
//  Description : Scoreboard bench for seq_bit_serializer. Two instances are
//                used: one MSB-first, one LSB-first, both WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_bit_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din_a, din_b;
  logic       dv_a, dv_b;
  logic       rdy_a, ser_a, bv_a, wl_a, busy_a;
  logic       rdy_b, ser_b, bv_b, wl_b, busy_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  int n_cmp = 0;
  int n_err = 0;
  int run_a = 0, last_run_a = 0;
  int run_b = 0, last_run_b = 0;
  int w;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .data_in(din_a), .data_valid(dv_a),
    .data_ready(rdy_a), .ser_bit(ser_a), .bit_valid(bv_a),
    .word_last(wl_a), .busy(busy_a)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .data_in(din_b), .data_valid(dv_b),
    .data_ready(rdy_b), .ser_bit(ser_b), .bit_valid(bv_b),
    .word_last(wl_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer a word (caller is positioned between edges); waits for ready,
  // queues the hand-computed bit sequence (first bit = seq[7]) and returns
  // just after the accepting edge. waits = extra cycles spent stalled.
  task automatic put(input int sel, input logic [7:0] wd, input logic [7:0] seq, output int waits);
    exp_t e;
    waits = 0;
    if (sel == 0) begin din_a = wd; dv_a = 1'b1; end
    else          begin din_b = wd; dv_b = 1'b1; end
    while (((sel == 0) ? rdy_a : rdy_b) !== 1'b1) begin
      if (waits >= 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL put_timeout: word %0h not accepted, waited %0d cycles, required < 50", wd, waits);
        dv_a = 1'b0;
        dv_b = 1'b0;
        return;
      end
      @(negedge clk);
      waits++;
    end
    for (int i = 7; i >= 0; i--) begin
      e.b    = seq[i];
      e.last = (i == 0);
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
    end
    @(posedge clk);
  endtask

  // Wait until bit_valid drops, then check the length of the finished run.
  task automatic wait_idle(input int sel, input int exp_run, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((((sel == 0) ? bv_a : bv_b) === 1'b1) && (n < 100));
    if (n >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: bit_valid still high after %0d cycles, required low", name, n);
    end
    #1;
    chk(name, (sel == 0) ? last_run_a : last_run_b, exp_run);
  endtask

  // Scoreboard monitor, MSB-first instance.
  always @(negedge clk) begin
    if (reset) begin
      run_a = 0;
    end else if (bv_a === 1'b1) begin
      run_a++;
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_a_extra: got bit %b, expected no bit", ser_a);
      end else begin
        e_a = q_a.pop_front();
        chk("sb_a_bit", ser_a, e_a.b);
        chk("sb_a_last", wl_a, e_a.last);
      end
    end else begin
      if (run_a != 0) begin
        last_run_a = run_a;
        run_a = 0;
      end
      chk("idle_a_ser", ser_a, 1'b0);
      chk("idle_a_last", wl_a, 1'b0);
    end
  end

  // Scoreboard monitor, LSB-first instance.
  always @(negedge clk) begin
    if (reset) begin
      run_b = 0;
    end else if (bv_b === 1'b1) begin
      run_b++;
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_b_extra: got bit %b, expected no bit", ser_b);
      end else begin
        e_b = q_b.pop_front();
        chk("sb_b_bit", ser_b, e_b.b);
        chk("sb_b_last", wl_b, e_b.last);
      end
    end else begin
      if (run_b != 0) begin
        last_run_b = run_b;
        run_b = 0;
      end
      chk("idle_b_ser", ser_b, 1'b0);
      chk("idle_b_last", wl_b, 1'b0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    dv_a = 1'b0; dv_b = 1'b0;
    din_a = 8'h00; din_b = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ser", ser_a, 1'b0);
    chk("rst_valid", bv_a, 1'b0);
    chk("rst_last", wl_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_ready", rdy_a, 1'b1);
    chk("rst_ready_b", rdy_b, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // Single word, MSB first: B0 -> 1,0,1,1,0,0,0,0
    put(0, 8'hB0, 8'b1011_0000, w);
    @(negedge clk);
    dv_a = 1'b0;
    wait_idle(0, 8, "t1_run");
    chk("t1_busy", busy_a, 1'b0);
    chk("t1_ready", rdy_a, 1'b1);

    // LSB first: 0D -> 1,0,1,1,0,0,0,0
    put(1, 8'h0D, 8'b1011_0000, w);
    @(negedge clk);
    dv_b = 1'b0;
    wait_idle(1, 8, "t2_run");

    // Back-to-back 01 then 60 across the boundary
    @(negedge clk);
    put(0, 8'h01, 8'b0000_0001, w);
    @(negedge clk);
    put(0, 8'h60, 8'b0110_0000, w);
    chk("t3_wait", w, 0);
    @(negedge clk);
    dv_a = 1'b0;
    chk("t3_ready_low", rdy_a, 1'b0);
    chk("t3_busy", busy_a, 1'b1);
    repeat (6) begin
      @(negedge clk);
      chk("t3_ready_low", rdy_a, 1'b0);
    end
    @(negedge clk);
    chk("t3_ready_rise", rdy_a, 1'b1);
    wait_idle(0, 16, "t3_run");

    // Last-bit bypass: second word offered only on word_last
    @(negedge clk);
    put(0, 8'hA5, 8'b1010_0101, w);
    @(negedge clk);
    dv_a = 1'b0;
    w = 0;
    while (wl_a !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t4_last_seen", w, 7);
    put(0, 8'hC3, 8'b1100_0011, w);
    chk("t4_wait", w, 0);
    @(negedge clk);
    dv_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_ready_high", rdy_a, 1'b1);
      @(negedge clk);
    end
    wait_idle(0, 16, "t4_run");

    // Backpressure: three words with valid held high
    @(negedge clk);
    put(0, 8'h3C, 8'b0011_1100, w);
    @(negedge clk);
    put(0, 8'h96, 8'b1001_0110, w);
    chk("t5_wait2", w, 0);
    @(negedge clk);
    put(0, 8'hE1, 8'b1110_0001, w);
    chk("t5_wait3", w, 7);
    @(negedge clk);
    dv_a = 1'b0;
    wait_idle(0, 24, "t5_run");

    // Reset mid-word (bit 3) with the holding register full
    @(negedge clk);
    put(0, 8'h5A, 8'b0101_1010, w);
    @(negedge clk);
    put(0, 8'hFF, 8'b1111_1111, w);
    @(negedge clk);
    dv_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_ready", rdy_a, 1'b0);
    chk("t6_pre_ser", ser_a, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_ser", ser_a, 1'b0);
    chk("t6_valid", bv_a, 1'b0);
    chk("t6_last", wl_a, 1'b0);
    chk("t6_busy", busy_a, 1'b0);
    chk("t6_ready", rdy_a, 1'b1);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_post_valid", bv_a, 1'b0);
    put(0, 8'h93, 8'b1001_0011, w);
    @(negedge clk);
    dv_a = 1'b0;
    wait_idle(0, 8, "t6_run");

    chk("end_q_a", q_a.size(), 0);
    chk("end_q_b", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Upstream feed stage for the 1011 sequence detector. Accepts parallel words over a valid/ready handshake and emits them as a continuous serial bit stream, one bit per clock. The output `ser_bit` drives the detector's `inp_bit` directly. A one-entry holding register lets consecutive words stream back-to-back with no idle cycle, so patterns that span word boundaries are detected.

## Interface
Parameters:
- `WIDTH`, default 8: word width in bits, ≥2.
- `MSB_FIRST`, default 1: 1 sends bit `WIDTH-1` first; 0 sends bit 0 first.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_in`  input  WIDTH  parallel word to serialize.
- `data_valid`  input  1  `data_in` is valid this cycle.
- `data_ready`  output  1  block can accept a word this cycle.
- `ser_bit`  output  1  current serial bit (to detector `inp_bit`).
- `bit_valid`  output  1  `ser_bit` carries a real data bit this cycle.
- `word_last`  output  1  `ser_bit` is the final bit of its word.
- `busy`  output  1  shifter or holding register is occupied.

## Operation
- Storage:
  - shift register `sh[WIDTH-1:0]`.
  - bit counter `cnt`, width `$clog2(WIDTH)`.
  - holding register `hold[WIDTH-1:0]` with flag `hold_full`.
  - state `st` ∈ {IDLE, SHIFT}.
- Accept: a word is taken on a rising edge where `data_valid && data_ready`.
- `data_ready = !hold_full`. It is combinational from registers only and never depends on `data_valid`.
- IDLE:
  - On accept: load `sh` from `data_in`, set `cnt=0`, go to SHIFT. `hold` is untouched.
  - With no accept: stay in IDLE.
- SHIFT, cnt < WIDTH-1:
  - Advance the next bit into the output position and increment `cnt`.
  - On accept: write `data_in` into `hold` and set `hold_full=1`.
- SHIFT, cnt == WIDTH-1 (last bit being presented):
  - If `hold_full`: load `sh` from `hold`, clear `hold_full`, set `cnt=0`, stay in SHIFT. `data_ready` was 0, so no accept is possible.
  - Else if accept this edge: load `sh` from `data_in` (bypass), set `cnt=0`, stay in SHIFT.
  - Else: go to IDLE.
- Outputs:
  - `ser_bit` = the output-position bit of `sh`: `sh[WIDTH-1]` when MSB_FIRST=1, `sh[0]` otherwise. Forced to 0 in IDLE.
  - `bit_valid = (st==SHIFT)`.
  - `word_last = (st==SHIFT && cnt==WIDTH-1)`.
  - `busy = (st==SHIFT) || hold_full`.
- Idle gaps present `ser_bit=0` to the detector. This is intended: a gap acts as '0' bits for pattern purposes.
- No data is ever dropped or duplicated. Every accepted word emits exactly WIDTH bits in order.

## Timing
- Reset (asynchronous assert, deasserts synchronously to `clk` externally):
  - State: `st=IDLE`, `cnt=0`, `sh=0`, `hold=0`, `hold_full=0`.
  - Outputs: `ser_bit=0`, `bit_valid=0`, `word_last=0`, `busy=0`, `data_ready=1`.
- Reset mid-word: the in-flight word and any held word are discarded. The cycle after reset releases shows IDLE outputs.
- Latency: a word accepted at edge k presents its first bit in the cycle after edge k, and its last bit in the cycle after edge k+WIDTH-1.
- Back-to-back: with `data_valid` held high, bits stream continuously with `bit_valid` never dropping. Steady-state throughput is one word per WIDTH cycles.
- `data_ready`:
  - Falls the cycle after a word lands in `hold`.
  - Rises the cycle after `hold` is transferred to `sh`.
- `data_valid` without `data_ready` has no effect. The source must hold `data_in` stable until accepted.
- Simultaneous events:
  - A last-bit reload from `hold` takes priority over new input; input is blocked by `data_ready=0`.
  - An accept in IDLE and an accept on the last bit with empty hold both bypass `hold`.

## Test plan
- Reset mid-stream:
  - Stimulus: assert `reset` asynchronously during bit 3 of a word, with `hold_full=1`.
  - Required: outputs zero immediately; `data_ready=1`; the next accepted word starts cleanly from bit 0.
- Single word, WIDTH=8, MSB_FIRST=1:
  - Stimulus: accept 8'hB0.
  - Required: `ser_bit` sequence 1,0,1,1,0,0,0,0 on 8 consecutive cycles; `bit_valid=1` for exactly those 8 cycles; `word_last` only on the 8th; then IDLE with `ser_bit=0`.
- LSB-first:
  - Stimulus: MSB_FIRST=0, accept 8'h0D.
  - Required: sequence 1,0,1,1,0,0,0,0.
- Back-to-back across the boundary:
  - Stimulus: hold `data_valid=1`; send 8'h01 then 8'h60.
  - Required: 16 contiguous valid bits with no gap, ending ...0,0,0,1 | 0,1,1,0...; `data_ready` low while `hold` is full.
- Last-bit bypass:
  - Stimulus: present the second word only on the cycle where `word_last=1` of the first word.
  - Required: the word is accepted and its bit 0 follows with no gap; `hold_full` stays 0.
- Backpressure:
  - Stimulus: hold `data_valid=1` with three queued words.
  - Required: the third word is accepted only after the second moves to `sh`; all 24 bits are emitted in order with no loss.
